// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and the
// helper that sizes the per-phase cycle counter.
package pulse_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HIGH = 2'b01,
      GAP  = 2'b10
   } pulseState_t;

   // The counter holds (phase length - 1), so clog2 of the longest phase suffices.
   function automatic int cntWidth(input int highCyc, input int gapCyc);
      int longest;
      longest = (highCyc > gapCyc) ? highCyc : gapCyc;
      return (longest < 2) ? 1 : $clog2(longest);
   endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter for queued requests; a simultaneous inc and dec
// cancel out, and an inc that cannot be stored is flagged as dropped.
module sat_updown_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         full,
   output logic         dropped
);

   logic [W-1:0] r_count;

   assign count   = r_count;
   assign full    = (r_count == {W{1'b1}});
   assign dropped = inc & ~dec & full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && !dec && !full) begin
         r_count <= r_count + W'(1);
      end else if (dec && !inc && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

endmodule

// File: rtl/pulse_stretch_tx.sv
// Turns one-clock request pulses into registered HIGH_CYC-wide pulses separated
// by at least GAP_CYC low cycles, queueing requests that arrive while busy.
module pulse_stretch_tx
   import pulse_tx_pkg::*;
#(
   parameter int HIGH_CYC = 4,
   parameter int GAP_CYC  = 2,
   parameter int PEND_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              clr_ovf,
   output logic              asynch_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int CW = cntWidth(HIGH_CYC, GAP_CYC);
   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

   pulseState_t   r_state;
   pulseState_t   w_nextState;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_nextCnt;
   logic          r_out;
   logic          r_ovf;
   logic          w_pendNz;
   logic          w_work;
   logic          w_take;
   logic          w_inc;
   logic          w_dec;
   logic          w_full;
   logic          w_dropped;

   assign w_pendNz = (pending != '0);
   assign w_work   = pulse_in | w_pendNz;

   // A HIGH entry drains the queue first; a live request only bypasses it when empty.
   assign w_dec = w_take & w_pendNz;
   assign w_inc = pulse_in & ~(w_take & ~w_pendNz);

   sat_updown_cnt #(
      .W(PEND_W)
   ) u_pendCnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_inc),
      .dec    (w_dec),
      .count  (pending),
      .full   (w_full),
      .dropped(w_dropped)
   );

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_take      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_work) begin
               w_nextState = HIGH;
               w_nextCnt   = HIGH_LOAD;
               w_take      = 1'b1;
            end
         end
         HIGH: begin
            if (r_cnt == '0) begin
               w_nextState = GAP;
               w_nextCnt   = GAP_LOAD;
            end else begin
               w_nextCnt = r_cnt - CW'(1);
            end
         end
         GAP: begin
            if (r_cnt != '0) begin
               w_nextCnt = r_cnt - CW'(1);
            end else if (w_work) begin
               w_nextState = HIGH;
               w_nextCnt   = HIGH_LOAD;
               w_take      = 1'b1;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_out   <= (w_nextState == HIGH);
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_dropped) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign asynch_out = r_out;
   assign overflow   = r_ovf;
   assign busy       = (r_state != IDLE) | w_pendNz;

endmodule
